dcache_nway: RTL
================

Name: dcache_nway

Overview:
Parametrised N-way set-associative data-cache array, the successor to the fixed 2-way dcache storage.
- Holds data words, physical tags, per-line valid/dirty flags, and a tree pseudo-LRU per set.
- Sits behind the memory0/memory1 stages: memory0 issues reads, memory1 issues fills, stores and LRU updates.
- Adds a way-select output, explicit write-way addressing, and a sequential invalidate-all flush engine.

Parameters:
WAYS, 4, associativity; power of two, >=2
SETS, 256, number of sets; power of two
LINE_WORDS, 4, 32-bit words per line; power of two
TAG_W, 17, physical tag width (PA[28:12] at defaults)
Derived: WAY_W=$clog2(WAYS), SET_W=$clog2(SETS), OFF_W=$clog2(LINE_WORDS), IDX_W=SET_W+OFF_W

Ports:
clk_core  in  1  core clock
reset_n  in  1  asynchronous active-low reset
read_req  in  1  lookup request
read_index  in  IDX_W  {set, word offset}
read_tag  in  TAG_W  physical tag to compare (presented same cycle as read_req)
read_hit  out  1  registered hit result
read_way  out  WAY_W  registered hitting way
read_data  out  32  registered word from hitting way
victim_way  out  WAYS_W  registered PLRU victim for the looked-up set
victim_tag  out  TAG_W  tag stored in victim_way
victim_flags  out  2  {dirty,valid} of victim_way
write_req  in  1  write word + tag + flags
write_way  in  WAY_W  target way
write_index  in  IDX_W  {set, word offset}
write_data  in  32  write data
write_mask  in  4  byte enables
write_tag  in  TAG_W  tag written to write_way
write_flags  in  2  {dirty,valid} written to write_way
lru_update  in  1  mark read_way of last registered lookup as most recently used
flush_req  in  1  start invalidate-all
flush_busy  out  1  flush in progress
flush_done  out  1  one-cycle pulse at flush completion

Behaviour:
- Reset (async): all valid/dirty flags 0, all PLRU bits 0, FSM IDLE, set counter 0.
- Reset (async): read_hit, read_way, read_data, victim_*, flush_busy, flush_done all 0. Data/tag arrays are not reset.
- Lookup, 1-cycle latency: read_req at cycle N gives read_hit/read_way/read_data/victim_* valid at N+1, held until the next read_req.
- read_hit = OR over ways of (valid & tag==read_tag).
- Multiple matching ways is illegal (assertion); the lowest-index matching way wins.
- read_data is undefined-but-stable on a miss.
- Write: on write_req, at the clock edge, update bytes of data[write_way][set][offset] per write_mask.
- Write: tag[write_way][set] <= write_tag and flags <= write_flags, regardless of mask.
- Read and write in the same cycle: the read sees pre-write state for tags, flags and data (no bypass).
- PLRU: tree of WAYS-1 bits per set. Victim = follow bits from root (0 = left).
- PLRU update: lru_update flips the bits on the path of the registered read_way of the registered set to point away from it.
- PLRU update: lru_update without a preceding hit is a no-op; lru_update and a new read_req in the same cycle use the old registered set/way.
- Victim preference: if any way in the set is invalid, victim_way = lowest invalid way, overriding PLRU.
- Flush FSM, IDLE -> SWEEP on flush_req: flush_busy=1 from the next cycle.
- SWEEP: each cycle clear valid, dirty and PLRU for set counter; counter+1.
- SWEEP -> DONE after set SETS-1 (exactly SETS cycles).
- DONE: flush_done=1 for one cycle, flush_busy=0, -> IDLE.
- During SWEEP/DONE: read_req returns read_hit=0; write_req and lru_update are ignored; flush_req is ignored.
- Reset mid-sweep: immediate IDLE, everything invalid.
- Counter wraps to 0 on exit.

Decomposition:
- dcache_pkg: dcache_flags_t packed struct {dirty, valid}; FLAG_VALID/FLAG_DIRTY indices; flush_state_t enum {IDLE, SWEEP, DONE}.
- Sub-module dcache_plru: combinational, parametrised by WAYS. Inputs: tree bits, accessed way, valid vector. Outputs: next tree bits, victim way. Instantiated once on the registered set.

Test Plan:
- Fill then hit: write way2 set 5 offset 1, tag 0x1ABCD, flags 2'b01, data 0xDEADBEEF, mask 4'hF; read same index/tag -> next cycle read_hit=1, read_way=2, read_data=0xDEADBEEF.
- Byte mask: write 0x11223344 mask 4'b0101 over 0xDEADBEEF -> read_data=0xDE22BE44; tag mismatch 0x1ABCE -> read_hit=0.
- PLRU, WAYS=4: fill all four ways of set 7; hit and lru_update ways 0,1,2,3 in order -> victim_way=0. Then hit way 0 with lru_update -> victim_way=2.
- Invalid preference: set 9 with only way 1 valid -> victim_way=0, victim_flags=2'b00.
- Flush: flush_req with dirty lines present -> flush_busy high for exactly 256 cycles, single flush_done pulse. Reads during the flush miss; afterwards every set reads miss with victim_flags=0.
- Reset mid-flush (set counter=100) and read/write same-cycle collision: after release, flush_busy=0 and all lines miss. A simultaneous read and write to the same index returns the old data; the following read returns the new data.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types for the N-way data cache array: per-line flags and flush FSM states.
package dcache_pkg;

   typedef struct packed {
      logic dirty;
      logic valid;
   } dcache_flags_t;

   localparam int FLAG_VALID = 0;
   localparam int FLAG_DIRTY = 1;

   typedef enum logic [1:0] {
      IDLE,
      SWEEP,
      DONE
   } flush_state_t;

endpackage

// File: rtl/dcache_plru.sv
// Tree pseudo-LRU for one set: next-state bits for an access and victim selection.
// Heap-ordered tree (node n has children 2n+1 / 2n+2); a 0 bit points left.
module dcache_plru #(
   parameter int  WAYS  = 4,
   localparam int WAY_W = $clog2(WAYS)
) (
   input  logic [WAYS-2:0]  tree_bits,
   input  logic [WAY_W-1:0] access_way,
   input  logic [WAYS-1:0]  valid_vec,
   output logic [WAYS-2:0]  next_bits,
   output logic [WAY_W-1:0] victim_way
);

   logic [WAY_W-1:0] tree_victim;
   logic [WAY_W-1:0] inv_way;
   logic             inv_found;

   // Walk root-to-leaf along the accessed way, pointing each node away from it
   always_comb begin
      int node;
      node      = 0;
      next_bits = tree_bits;
      for (int l = 0; l < WAY_W; l++) begin
         for (int n = 0; n < WAYS-1; n++) begin
            if (n == node) next_bits[n] = ~access_way[WAY_W-1-l];
         end
         node = 2*node + 1 + (access_way[WAY_W-1-l] ? 1 : 0);
      end
   end

   always_comb begin
      int   node;
      logic b;
      node        = 0;
      tree_victim = '0;
      for (int l = 0; l < WAY_W; l++) begin
         b = 1'b0;
         for (int n = 0; n < WAYS-1; n++) begin
            if (n == node) b = tree_bits[n];
         end
         tree_victim[WAY_W-1-l] = b;
         node = 2*node + 1 + (b ? 1 : 0);
      end
   end

   // An empty way always beats the tree choice
   always_comb begin
      inv_way   = '0;
      inv_found = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!valid_vec[w] && !inv_found) begin
            inv_way   = WAY_W'(w);
            inv_found = 1'b1;
         end
      end
      victim_way = inv_found ? inv_way : tree_victim;
   end

endmodule

// File: rtl/dcache_nway.sv
// N-way set-associative data-cache array: data/tag/flag storage, registered lookup,
// tree PLRU with invalid-way preference, and a one-set-per-cycle invalidate-all engine.
module dcache_nway
   import dcache_pkg::*;
#(
   parameter int  WAYS       = 4,
   parameter int  SETS       = 256,
   parameter int  LINE_WORDS = 4,
   parameter int  TAG_W      = 17,
   localparam int WAY_W      = $clog2(WAYS),
   localparam int SET_W      = $clog2(SETS),
   localparam int OFF_W      = $clog2(LINE_WORDS),
   localparam int IDX_W      = SET_W + OFF_W
) (
   input  logic             clk_core,
   input  logic             reset_n,
   input  logic             read_req,
   input  logic [IDX_W-1:0] read_index,
   input  logic [TAG_W-1:0] read_tag,
   output logic             read_hit,
   output logic [WAY_W-1:0] read_way,
   output logic [31:0]      read_data,
   output logic [WAY_W-1:0] victim_way,
   output logic [TAG_W-1:0] victim_tag,
   output logic [1:0]       victim_flags,
   input  logic             write_req,
   input  logic [WAY_W-1:0] write_way,
   input  logic [IDX_W-1:0] write_index,
   input  logic [31:0]      write_data,
   input  logic [3:0]       write_mask,
   input  logic [TAG_W-1:0] write_tag,
   input  logic [1:0]       write_flags,
   input  logic             lru_update,
   input  logic             flush_req,
   output logic             flush_busy,
   output logic             flush_done
);

   logic [31:0]      data_mem [WAYS][SETS*LINE_WORDS];
   logic [TAG_W-1:0] tag_mem  [WAYS][SETS];
   dcache_flags_t    flags    [WAYS][SETS];
   logic [WAYS-2:0]  plru     [SETS];

   flush_state_t     state, next_state;
   logic [SET_W-1:0] flush_set;
   logic             idle;

   logic [SET_W-1:0] rd_set, wr_set, rd_set_q;
   logic [WAYS-1:0]  hit_vec, vic_valid;
   logic [WAY_W-1:0] hit_way, pl_victim;
   logic [WAYS-2:0]  plru_next;
   logic             lookup_vld_q;

   assign idle   = (state == IDLE);
   assign rd_set = read_index[IDX_W-1:OFF_W];
   assign wr_set = write_index[IDX_W-1:OFF_W];

   always_comb begin
      hit_vec = '0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++)
         hit_vec[w] = flags[w][rd_set].valid && (tag_mem[w][rd_set] == read_tag);
      for (int w = WAYS-1; w >= 0; w--)
         if (hit_vec[w]) hit_way = WAY_W'(w);
   end

   assert property (@(posedge clk_core) disable iff (!reset_n) read_req |-> $onehot0(hit_vec));

   // Lookup results; array reads here sample pre-write contents of the same edge
   always_ff @(posedge clk_core or negedge reset_n) begin
      if (!reset_n) begin
         read_hit     <= 1'b0;
         read_way     <= '0;
         read_data    <= '0;
         rd_set_q     <= '0;
         lookup_vld_q <= 1'b0;
      end else if (read_req) begin
         read_hit     <= idle && (|hit_vec);
         read_way     <= hit_way;
         read_data    <= data_mem[hit_way][read_index];
         rd_set_q     <= rd_set;
         lookup_vld_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_core) begin
      if (write_req && idle) begin
         for (int b = 0; b < 4; b++)
            if (write_mask[b]) data_mem[write_way][write_index][8*b +: 8] <= write_data[8*b +: 8];
         tag_mem[write_way][wr_set] <= write_tag;
      end
   end

   always_comb begin
      for (int w = 0; w < WAYS; w++) vic_valid[w] = flags[w][rd_set_q].valid;
   end

   dcache_plru #(.WAYS(WAYS)) u_plru (
      .tree_bits  (plru[rd_set_q]),
      .access_way (read_way),
      .valid_vec  (vic_valid),
      .next_bits  (plru_next),
      .victim_way (pl_victim)
   );

   // Victim view tracks the last looked-up set, so it reflects any lru_update since
   assign victim_way   = lookup_vld_q ? pl_victim : '0;
   assign victim_tag   = lookup_vld_q ? tag_mem[pl_victim][rd_set_q] : '0;
   assign victim_flags = lookup_vld_q ? flags[pl_victim][rd_set_q] : 2'b00;

   always_ff @(posedge clk_core or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < SETS; s++) begin
            plru[s] <= '0;
            for (int w = 0; w < WAYS; w++) flags[w][s] <= '0;
         end
      end else if (state == SWEEP) begin
         plru[flush_set] <= '0;
         for (int w = 0; w < WAYS; w++) flags[w][flush_set] <= '0;
      end else if (idle) begin
         if (write_req) flags[write_way][wr_set] <= dcache_flags_t'(write_flags);
         if (lru_update && read_hit) plru[rd_set_q] <= plru_next;
      end
   end

   always_ff @(posedge clk_core or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         flush_set <= '0;
      end else begin
         state <= next_state;
         if (state == SWEEP) flush_set <= flush_set + 1'b1;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (flush_req) next_state = SWEEP;
         SWEEP:   if (flush_set == SET_W'(SETS-1)) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   assign flush_busy = (state == SWEEP);
   assign flush_done = (state == DONE);

endmodule
